// File: rtl/cache_write_buffer.sv
// cache_write_buffer: write-back buffer between the 2-way data cache and main memory.
// Dirty evictions (address + word) are queued in a circular FIFO and drained to memory
// in arrival order over a req/ack handshake. Read misses look the buffer up
// combinationally, so a pending word is always forwarded rather than read stale.
//
// Build option: define WB_COALESCE_EN so that a push hitting a pending entry that is not
// in flight overwrites that entry's data instead of allocating a new slot.
module cache_write_buffer #(
  parameter int DEPTH = 4,   // entries; power of two, >= 2
  parameter int AW    = 32,  // address width
  parameter int DW    = 32   // data width
) (
  input  logic                       clk,
  input  logic                       reset,
  // eviction push from the cache
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DW-1:0]              wb_data,
  output logic                       wb_ready,
  // read-miss lookup
  input  logic [AW-1:0]              lk_addr,
  output logic                       lk_hit,
  output logic [DW-1:0]              lk_data,
  // memory write port
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ack,
  // occupancy
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Entry storage
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  // Control state
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  state_e        state_q,  state_d;

  // Per-cycle events
  logic          push;       // wb_valid && wb_ready
  logic          alloc;      // accepted push that takes a new slot
  logic          coal;       // accepted push that overwrites a pending slot
  logic [PW-1:0] coal_idx;   // slot overwritten by a coalescing push
  logic          pop;        // head retired by memory this edge

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign pop   = (state_q == REQ) && mem_ack;
  assign push  = wb_valid && wb_ready;

`ifdef WB_COALESCE_EN
  logic coal_hit;

  // Find the youngest pending entry matching wb_addr that memory is not currently writing
  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every variable written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    coal_hit = 1'b0;
    coal_idx = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // NOTE: blocking '=' in combinational logic: later loop iterations must see the
      // value just written, which is what lets the youngest match win.
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_mem[idx] == wb_addr) &&
          !((k == 0) && (state_q == REQ))) begin
        coal_hit = 1'b1;
        coal_idx = idx;
      end
    end
  end

  assign wb_ready = !full || coal_hit;
  assign alloc    = push && !coal_hit;
  assign coal     = push && coal_hit;
`else
  assign wb_ready = !full;
  assign alloc    = push;
  assign coal     = 1'b0;
  assign coal_idx = '0;
`endif

  // Forwarding lookup: oldest to youngest so the youngest match wins, then the same-cycle push
  always_comb begin
    logic [PW-1:0] idx;
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_mem[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_mem[idx];
      end
    end
    if (push && (wb_addr == lk_addr)) begin
      lk_hit  = 1'b1;
      lk_data = wb_data;
    end
  end

  // Next pointers and occupancy from this cycle's allocate/pop events
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (alloc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({alloc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM next state: request the head once the buffer is non-empty, hold until ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = REQ;
      REQ:     if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port: mem_req is the REQ state flop; address/data are the held head entry
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = mem_req ? addr_mem[rd_ptr_q] : '0;
  assign mem_wdata = mem_req ? data_mem[rd_ptr_q] : '0;

  // Control registers; reset empties the buffer and drops any in-flight request at once
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Entry storage writes: new slot on allocate, data overwrite on coalesce
  always_ff @(posedge clk) begin
    // NOTE: the entry arrays are not reset; a slot is only ever read once count covers it,
    // and it is always written before that.
    if (alloc) begin
      addr_mem[wr_ptr_q] <= wb_addr;
      data_mem[wr_ptr_q] <= wb_data;
    end
    if (coal) begin
      data_mem[coal_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// tb_cache_write_buffer: directed scenarios plus randomized traffic for cache_write_buffer.
// A queue-based model of the pending entries acts as the scoreboard: accepted pushes
// append (or coalesce into) expected entries, and the monitor compares every DUT output
// each cycle and retires the head when memory acknowledges it.
module tb_cache_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  int   n_vec = 0;
  int   n_mis = 0;
  int   n_drained = 0;

  // Reference model: pending entries oldest-first, and whether the head is being requested
  ent_t exp_q[$];
  bit   inflight = 1'b0;

  cache_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .lk_addr   (lk_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare outputs mid-cycle, then advance the model across the next edge
  always @(negedge clk) begin : monitor
    int            sz0;
    int            j;
    bit            exp_ready;
    bit            acc;
    bit            exp_hit;
    logic [DW-1:0] exp_data;
    if (reset) begin
      exp_q.delete();
      inflight = 1'b0;
      check("rst_mem_req",  mem_req,  1'b0);
      check("rst_empty",    empty,    1'b1);
      check("rst_full",     full,     1'b0);
      check("rst_count",    count,    '0);
      check("rst_wb_ready", wb_ready, 1'b1);
      check("rst_lk_hit",   lk_hit,   1'b0);
      check("rst_mem_addr", mem_addr, '0);
      check("rst_mem_wdata",mem_wdata,'0);
    end else begin
      sz0 = exp_q.size();
      check("count",   count,   sz0);
      check("empty",   empty,   sz0 == 0);
      check("full",    full,    sz0 == DEPTH);
      check("mem_req", mem_req, inflight);
      if (inflight) begin
        check("mem_addr",  mem_addr,  exp_q[0].addr);
        check("mem_wdata", mem_wdata, exp_q[0].data);
      end

      // Which pending entry, if any, a push to wb_addr would coalesce into
      j = -1;
`ifdef WB_COALESCE_EN
      for (int i = 0; i < sz0; i++)
        if (exp_q[i].addr == wb_addr && !(i == 0 && inflight)) j = i;
`endif
      exp_ready = (sz0 < DEPTH) || (j >= 0);
      check("wb_ready", wb_ready, exp_ready);
      acc = wb_valid && exp_ready;

      // Lookup: youngest pending match, overridden by an accepted same-cycle push
      exp_hit  = 1'b0;
      exp_data = '0;
      for (int i = 0; i < sz0; i++)
        if (exp_q[i].addr == lk_addr) begin
          exp_hit  = 1'b1;
          exp_data = exp_q[i].data;
        end
      if (acc && wb_addr == lk_addr) begin
        exp_hit  = 1'b1;
        exp_data = wb_data;
      end
      check("lk_hit",  lk_hit,  exp_hit);
      check("lk_data", lk_data, exp_data);

      // Advance model across the coming edge
      if (acc) begin
        if (j >= 0) exp_q[j].data = wb_data;
        else        exp_q.push_back('{wb_addr, wb_data});
      end
      if (inflight && mem_ack) begin
        void'(exp_q.pop_front());
        inflight = 1'b0;
        n_drained++;
      end else if (!inflight && sz0 > 0) begin
        inflight = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget  = 0;
    mem_ack = 1'b1;
    while ((exp_q.size() != 0 || inflight) && budget < 60) begin
      step();
      budget++;
    end
    check("drain_done", (exp_q.size() == 0 && !inflight), 1'b1);
    mem_ack = 1'b0;
    step();
  endtask

  // Stimulus
  initial begin
    int drained0;
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    lk_addr  = '0;
    mem_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Single entry, ack three cycles after mem_req rises
    push(32'h100, 32'hDEAD_BEEF);
    lk_addr = 32'h100;
    repeat (4) step();
    drained0 = n_drained;
    drain();
    check("single_drained", n_drained - drained0, 1);

    // Fill to DEPTH with ack held low, then overflow push
    push(32'h10, 32'h1010);
    push(32'h14, 32'h1414);
    push(32'h18, 32'h1818);
    push(32'h1C, 32'h1C1C);
    push(32'h20, 32'h2020);
    check("fill_full", full, 1'b1);
    drained0 = n_drained;
    drain();
    check("fill_drained", n_drained - drained0, DEPTH);

    // Two writes to one address: lookup must forward the younger one
    push(32'h40, 32'hA);
    push(32'h40, 32'hB);
    lk_addr = 32'h40; step();
    check("fwd_40_hit",  lk_hit,  1'b1);
    check("fwd_40_data", lk_data, 32'hB);
    lk_addr = 32'h44; step();
    check("fwd_44_miss", lk_hit,  1'b0);
    check("fwd_44_data", lk_data, 32'h0);
    drain();

    // Duplicate-address sequence (coalesce vs allocate)
    push(32'h10, 32'h1);
    push(32'h20, 32'h2);
    push(32'h20, 32'h3);
`ifdef WB_COALESCE_EN
    check("dup_count", count, 2);
`else
    check("dup_count", count, 3);
`endif
    drain();

    // Reset while a request is outstanding with three entries queued
    push(32'h50, 32'h5);
    push(32'h54, 32'h6);
    push(32'h58, 32'h7);
    step();
    check("pre_rst_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_drop_req",   mem_req, 1'b0);
    check("rst_drop_count", count,   '0);
    step();
    reset = 1'b0;
    step();
    push(32'h60, 32'h66);
    check("post_rst_count", count, 1);
    drain();

    // Randomized traffic over a small address pool to exercise matches and full/empty edges
    for (int c = 0; c < 3000; c++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr  = 32'h10 + 32'(4 * $urandom_range(0, 5));
      wb_data  = $urandom;
      lk_addr  = 32'h10 + 32'(4 * $urandom_range(0, 6));
      if ((c / 200) % 3 == 2) mem_ack = 1'b0;
      else                    mem_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    wb_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
